// File: rtl/tank_irrigation_ctrl.sv
// tank_irrigation_ctrl
// Reservoir/irrigation controller. Watches an N-bit thermometer-coded level
// sensor array, drives the inlet valve with hysteresis, and runs a timed
// sprinkler or drip cycle with an mm:ss countdown for the display stage.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   level_raw[N-1:0]    raw level sensors, bit 0 lowest, 1 = wet
//   req_sprinkle        sprinkler mode select (sampled at start event)
//   req_drip            drip mode select (sampled at start event)
//   start               start request, rising edge detected internally
//   valve_in            inlet valve open
//   valve_out           gravity outlet valve open (drip)
//   pump                sprinkler pump on
//   alarm               tank empty or sensor fault
//   error               debounced sensor pattern is not thermometer code
//   busy                irrigation cycle active
//   minutes, seconds    remaining cycle time
//
// Handshake: none; start is a plain level whose rising edge is the request,
// mode selects are only looked at on that edge.
//
// Build option: define IRR_PAUSE_EN to pause (instead of abort) a running
// cycle on low level; the cycle resumes without reload when level returns.
module tank_irrigation_ctrl #(
    parameter int NUM_LEVELS         = 3,
    parameter int FILL_START_LEVEL   = 1,
    parameter int MIN_SPRINKLE_LEVEL = 2,
    parameter int TICK_DIV           = 50000000,
    parameter int DEBOUNCE_CYCLES    = 16,
    parameter int SPRINKLE_TIME_S    = 120,
    parameter int DRIP_TIME_S        = 300
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LEVELS-1:0] level_raw,
    input  logic                  req_sprinkle,
    input  logic                  req_drip,
    input  logic                  start,
    output logic                  valve_in,
    output logic                  valve_out,
    output logic                  pump,
    output logic                  alarm,
    output logic                  error,
    output logic                  busy,
    output logic [6:0]            minutes,
    output logic [5:0]            seconds
);

    localparam int CW = $clog2(NUM_LEVELS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = DW + 1;

    localparam logic [CW-1:0] FILL_LVL  = CW'(FILL_START_LEVEL);
    localparam logic [CW-1:0] SPR_LVL   = CW'(MIN_SPRINKLE_LEVEL);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] DB_LEN    = RW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]    SP_MIN    = 7'(SPRINKLE_TIME_S / 60);
    localparam logic [5:0]    SP_SEC    = 6'(SPRINKLE_TIME_S % 60);
    localparam logic [6:0]    DR_MIN    = 7'(DRIP_TIME_S / 60);
    localparam logic [5:0]    DR_SEC    = 6'(DRIP_TIME_S % 60);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPRINKLE,
        S_DRIP,
        S_FAULT
`ifdef IRR_PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    state_t state, state_n;

    // ---------------- sensor synchroniser + debounce ----------------
    logic [NUM_LEVELS-1:0] sync1, sync2, cand, lvl_db;
    logic [RW-1:0]         db_cnt, run;

    // run = length of the current streak of identical sync2 values,
    // counting this cycle; db_cnt saturates so it never wraps.
    assign run = (sync2 == cand) ? db_cnt + RW'(1) : RW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            db_cnt <= '0;
            lvl_db <= '0;
        end else begin
            sync1  <= level_raw;
            sync2  <= sync1;
            cand   <= sync2;
            db_cnt <= (run > DB_LEN) ? DB_LEN : run;
            if (run >= DB_LEN) lvl_db <= sync2;
        end
    end

    // ---------------- level decode ----------------
    logic [CW-1:0] lvl_cnt;
    logic          err_c, empty, full, spr_ok, drip_ok;

    always_comb begin
        lvl_cnt = '0;
        err_c   = 1'b0;
        for (int i = 0; i < NUM_LEVELS; i++) lvl_cnt = lvl_cnt + CW'(lvl_db[i]);
        // a wet sensor above a dry one cannot happen in a real tank
        for (int i = 0; i < NUM_LEVELS - 1; i++)
            if (lvl_db[i+1] && !lvl_db[i]) err_c = 1'b1;
    end

    assign empty   = (lvl_cnt == '0);
    assign full    = &lvl_db;
    assign spr_ok  = (lvl_cnt >= SPR_LVL);
    assign drip_ok = !empty;

    // ---------------- inlet, alarm, error ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valve_in <= 1'b0;
            alarm    <= 1'b0;
            error    <= 1'b0;
        end else begin
            error <= err_c;
            alarm <= empty | err_c;
            if (err_c)                  valve_in <= 1'b0;
            else if (lvl_cnt < FILL_LVL) valve_in <= 1'b1;
            else if (full)              valve_in <= 1'b0;
        end
    end

    // ---------------- start edge ----------------
    logic start_q, start_evt;
    assign start_evt = start & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) start_q <= 1'b0;
        else     start_q <= start;
    end

    // ---------------- FSM + timer ----------------
    logic [TW-1:0] tick_cnt, tick_n;
    logic [DW-1:0] fault_cnt, fault_n;
    logic [6:0]    min_n, min_dec;
    logic [5:0]    sec_n, sec_dec;
    logic          tick, lvl_lost, busy_n;
`ifdef IRR_PAUSE_EN
    logic          mode_spr;
`endif

    assign tick = (tick_cnt == TICK_LAST);

    // one-second decrement, saturating at 00:00
    always_comb begin
        min_dec = minutes;
        sec_dec = seconds;
        if (seconds != 6'd0) begin
            sec_dec = seconds - 6'd1;
        end else if (minutes != 7'd0) begin
            sec_dec = 6'd59;
            min_dec = minutes - 7'd1;
        end
    end

    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        min_n    = minutes;
        sec_n    = seconds;
        fault_n  = '0;
        lvl_lost = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_evt) begin
                    if (req_sprinkle && spr_ok) begin
                        state_n = S_SPRINKLE;
                        tick_n  = '0;
                        min_n   = SP_MIN;
                        sec_n   = SP_SEC;
                    end else if (req_drip && drip_ok) begin
                        state_n = S_DRIP;
                        tick_n  = '0;
                        min_n   = DR_MIN;
                        sec_n   = DR_SEC;
                    end
                end
            end
            S_SPRINKLE, S_DRIP: begin
                lvl_lost = (state == S_SPRINKLE) ? !spr_ok : !drip_ok;
                // low level takes precedence over a coincident tick: the
                // remaining time is kept exactly as displayed
                if (lvl_lost) begin
`ifdef IRR_PAUSE_EN
                    state_n = S_PAUSED;
`else
                    state_n = S_IDLE;
`endif
                end else begin
                    tick_n = tick ? '0 : tick_cnt + TW'(1);
                    if (tick) begin
                        min_n = min_dec;
                        sec_n = sec_dec;
                        if (min_dec == 7'd0 && sec_dec == 6'd0) state_n = S_IDLE;
                    end
                end
            end
`ifdef IRR_PAUSE_EN
            S_PAUSED: begin
                if (mode_spr ? spr_ok : drip_ok)
                    state_n = mode_spr ? S_SPRINKLE : S_DRIP;
            end
`endif
            S_FAULT: begin
                min_n = '0;
                sec_n = '0;
                if (!err_c) begin
                    if (fault_cnt == DB_LAST) state_n = S_IDLE;
                    else                      fault_n = fault_cnt + DW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (err_c) begin
            state_n = S_FAULT;
            tick_n  = '0;
            min_n   = '0;
            sec_n   = '0;
        end

        busy_n = (state_n == S_SPRINKLE) || (state_n == S_DRIP);
`ifdef IRR_PAUSE_EN
        if (state_n == S_PAUSED) busy_n = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            fault_cnt <= '0;
            minutes   <= '0;
            seconds   <= '0;
            pump      <= 1'b0;
            valve_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            fault_cnt <= fault_n;
            minutes   <= min_n;
            seconds   <= sec_n;
            pump      <= (state_n == S_SPRINKLE);
            valve_out <= (state_n == S_DRIP);
            busy      <= busy_n;
        end
    end

`ifdef IRR_PAUSE_EN
    // remembers which mode to resume after a pause
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    mode_spr <= 1'b0;
        else if (state == S_SPRINKLE) mode_spr <= 1'b1;
        else if (state == S_DRIP)     mode_spr <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_tank_irrigation_ctrl.sv
module tb_tank_irrigation_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] level_raw;
    logic       req_sprinkle, req_drip, start;
    logic       valve_in, valve_out, pump, alarm, error, busy;
    logic [6:0] minutes;
    logic [5:0] seconds;

    int vectors     = 0;
    int miscompares = 0;

`ifdef IRR_PAUSE_EN
    localparam logic PB = 1'b1;
`else
    localparam logic PB = 1'b0;
`endif

    tank_irrigation_ctrl #(
        .NUM_LEVELS(3), .FILL_START_LEVEL(1), .MIN_SPRINKLE_LEVEL(2),
        .TICK_DIV(4), .DEBOUNCE_CYCLES(3),
        .SPRINKLE_TIME_S(61), .DRIP_TIME_S(2)
    ) dut (
        .clk(clk), .rst(rst), .level_raw(level_raw),
        .req_sprinkle(req_sprinkle), .req_drip(req_drip), .start(start),
        .valve_in(valve_in), .valve_out(valve_out), .pump(pump),
        .alarm(alarm), .error(error), .busy(busy),
        .minutes(minutes), .seconds(seconds)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // driver / checker tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // flags ordered {valve_in, valve_out, pump, alarm, error, busy}
    task automatic chk_flags(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {valve_in, valve_out, pump, alarm, error, busy};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s flags(vi,vo,pump,alarm,err,busy): got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_tmr(input string name, input int m, input int s);
        vectors++;
        if (minutes !== 7'(m) || seconds !== 6'(s)) begin
            miscompares++;
            $display("FAIL %s timer: got %0d:%0d expected %0d:%0d", name, minutes, seconds, m, s);
        end
    endtask

    typedef struct {
        logic [2:0] raw;
        logic       sp, dr, st;
        int         n;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        //          raw     sp    dr    st    n   vi vo p a e b
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 5,  6'b100100};
        tbl[1]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3,  6'b100100}; // not yet debounced
        tbl[2]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3,  6'b100000}; // accepted at 2+3
        tbl[3]  = '{3'b000, 1'b0, 1'b0, 1'b0, 2,  6'b100000}; // short glitch
        tbl[4]  = '{3'b001, 1'b0, 1'b0, 1'b0, 3,  6'b100000}; // glitch rejected
        tbl[5]  = '{3'b001, 1'b0, 1'b0, 1'b0, 5,  6'b100000};
        tbl[6]  = '{3'b011, 1'b0, 1'b0, 1'b0, 10, 6'b100000};
        tbl[7]  = '{3'b111, 1'b0, 1'b0, 1'b0, 4,  6'b100000};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, 1'b0, 6,  6'b000000}; // full closes inlet
        tbl[9]  = '{3'b011, 1'b0, 1'b0, 1'b0, 10, 6'b000000}; // hysteresis
        tbl[10] = '{3'b011, 1'b0, 1'b0, 1'b1, 2,  6'b000000}; // start, no mode
        tbl[11] = '{3'b011, 1'b0, 1'b0, 1'b0, 2,  6'b000000};

        // reset
        rst = 1'b1; level_raw = 3'b000;
        req_sprinkle = 1'b0; req_drip = 1'b0; start = 1'b0;
        cyc(2);
        chk_flags("reset", 6'b000000);
        chk_tmr("reset", 0, 0);
        rst = 1'b0;

        // table vectors: fill, debounce, hysteresis
        for (int i = 0; i < 12; i++) begin
            level_raw = tbl[i].raw; req_sprinkle = tbl[i].sp;
            req_drip = tbl[i].dr; start = tbl[i].st;
            cyc(tbl[i].n);
            chk_flags($sformatf("vec%0d", i), tbl[i].exp);
        end

        // sprinkle full cycle, both modes requested -> sprinkle wins
        req_sprinkle = 1'b1; req_drip = 1'b1; start = 1'b1;
        cyc(1);
        chk_flags("spr_entry", 6'b001001);
        chk_tmr("spr_entry", 1, 1);
        start = 1'b0;
        cyc(3);
        chk_tmr("spr_pre_tick", 1, 1);
        cyc(1);
        chk_tmr("spr_tick1", 1, 0);
        for (int k = 2; k <= 60; k++) begin
            if (k == 10) begin req_sprinkle = 1'b0; req_drip = 1'b0; end
            cyc(4);
            chk_tmr($sformatf("spr_tick%0d", k), (61 - k) / 60, (61 - k) % 60);
            chk_flags($sformatf("spr_run%0d", k), 6'b001001);
        end
        cyc(4);
        chk_tmr("spr_done", 0, 0);
        chk_flags("spr_done", 6'b000000);

        // sprinkle refused at low level, then drip
        level_raw = 3'b001;
        cyc(10);
        req_sprinkle = 1'b1; req_drip = 1'b0; start = 1'b1;
        cyc(1);
        chk_flags("spr_refused", 6'b000000);
        start = 1'b0;
        cyc(1);
        req_drip = 1'b1; start = 1'b1;
        cyc(1);
        chk_flags("drip_entry", 6'b010001);
        chk_tmr("drip_entry", 0, 2);
        start = 1'b0; level_raw = 3'b000;
        cyc(6);
        chk_flags("drip_empty", {5'b10010, PB});
        chk_tmr("drip_empty", 0, 1);
        cyc(8);
        chk_tmr("drip_held", 0, 1);
        level_raw = 3'b001;
`ifdef IRR_PAUSE_EN
        cyc(6);
        chk_flags("drip_resume", 6'b110001);
        chk_tmr("drip_resume", 0, 1);
        cyc(4);
        chk_flags("drip_finish", 6'b100000);
        chk_tmr("drip_finish", 0, 0);
`else
        cyc(10);
        chk_flags("drip_idle", 6'b100000);
        chk_tmr("drip_idle", 0, 1);
`endif

        // fault during drip, coincident start ignored
        req_sprinkle = 1'b0; req_drip = 1'b1; start = 1'b1;
        cyc(1);
        chk_flags("drip2_entry", 6'b110001);
        start = 1'b0; level_raw = 3'b101;
        cyc(4);
        chk_tmr("drip2_tick", 0, 1);
        cyc(1);
        start = 1'b1;
        cyc(1);
        chk_flags("fault_entry", 6'b000110);
        chk_tmr("fault_entry", 0, 0);
        start = 1'b0; level_raw = 3'b011;
        cyc(3);
        chk_flags("fault_hold", 6'b000110);
        cyc(3);
        chk_flags("fault_clear", 6'b000000);
        req_sprinkle = 1'b1; start = 1'b1;
        cyc(1);
        chk_flags("fault_start_ign", 6'b000000);
        start = 1'b0;
        cyc(4);

        // sprinkle with level dropping below the sprinkle minimum
        req_drip = 1'b0; start = 1'b1;
        cyc(1);
        chk_flags("spr2_entry", 6'b001001);
        chk_tmr("spr2_entry", 1, 1);
        start = 1'b0; level_raw = 3'b001;
        cyc(6);
        chk_flags("spr2_low", {5'b00000, PB});
        chk_tmr("spr2_low", 1, 0);
        cyc(8);
        chk_tmr("spr2_held", 1, 0);
        level_raw = 3'b011;
        cyc(6);
`ifdef IRR_PAUSE_EN
        chk_flags("spr2_resume", 6'b001001);
        chk_tmr("spr2_resume", 1, 0);
        cyc(2);
        chk_tmr("spr2_pre_tick", 1, 0);
        cyc(1);
        chk_tmr("spr2_tick", 0, 59);
`else
        chk_flags("spr2_idle", 6'b000000);
        chk_tmr("spr2_idle", 1, 0);
        start = 1'b1;
        cyc(1);
        chk_flags("spr3_entry", 6'b001001);
        chk_tmr("spr3_reload", 1, 1);
        start = 1'b0;
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
